// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES types, constants and small helpers for the round datapath.
//   - state_t : 4x4 byte state, indexed [row][col]; byte i of a FIPS-197
//               128-bit vector sits at [i%4][i/4].
//   - word_t  : 32-bit key-schedule word; column c of a state forms the word
//               {s[0][c], s[1][c], s[2][c], s[3][c]} (row 0 is the MSB).
//   - RCON    : key-schedule round constants for rounds 0..9.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 10;
    localparam int unsigned ROUND_W        = 4;

    typedef logic [7:0]       byte_t;
    typedef byte_t [3:0][3:0] state_t;
    typedef logic [31:0]      word_t;

    localparam byte_t RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for the expansion that follows round idx; rounds past
    // the table never expand (the schedule wraps to the stored key instead).
    function automatic byte_t rcon_lookup(input logic [ROUND_W-1:0] idx);
        byte_t r;
        case (idx)
            4'd0:    r = RCON[0];
            4'd1:    r = RCON[1];
            4'd2:    r = RCON[2];
            4'd3:    r = RCON[3];
            4'd4:    r = RCON[4];
            4'd5:    r = RCON[5];
            4'd6:    r = RCON[6];
            4'd7:    r = RCON[7];
            4'd8:    r = RCON[8];
            4'd9:    r = RCON[9];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Column c of a state viewed as a key-schedule word.
    function automatic word_t col_word(input state_t s, input logic [1:0] c);
        return {s[0][c], s[1][c], s[2][c], s[3][c]};
    endfunction

    // Rebuild a state from four column words (w0 is column 0).
    function automatic state_t words_to_state(input word_t w0, input word_t w1,
                                              input word_t w2, input word_t w3);
        state_t s;
        s[0] = {w3[31:24], w2[31:24], w1[31:24], w0[31:24]};
        s[1] = {w3[23:16], w2[23:16], w1[23:16], w0[23:16]};
        s[2] = {w3[15:8],  w2[15:8],  w1[15:8],  w0[15:8]};
        s[3] = {w3[7:0],   w2[7:0],   w1[7:0],   w0[7:0]};
        return s;
    endfunction

endpackage : aes_pkg

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Forward AES S-box, purely combinational. Shared by the key schedule here
//   and by the confusion (SubBytes) stage.
//   Ports:
//     plain  in  8  byte to substitute
//     subst  out 8  S-box image of plain
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t plain,
    output byte_t subst
);

    // NOTE: this is a constant lookup table that synthesises to logic; it has
    // no storage, so there is nothing to reset or initialise at run time.
    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[plain];

endmodule : aes_sbox

// File: rtl/round_key_add.sv
// ---------------------------------------------------------------------------
// round_key_add
//   AES-128 AddRoundKey stage sitting after ShiftRows+MixColumns. Each
//   accepted state is XORed with the current round key and registered; the
//   next round key is expanded on the fly, one step per accepted state.
//   After round NUM_ROUNDS the schedule wraps back to the stored cipher key.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     key_load     pulse: capture cipher_key, restart schedule at round 0
//     cipher_key   AES-128 key, byte[row][col]
//     state_in     state from diffusion, byte[row][col]
//     in_valid     state_in valid
//     in_ready     stage accepts state_in this cycle (combinational)
//     state_out    state_in XOR round key, registered
//     out_round    round index applied to state_out
//     out_valid    state_out valid
//     out_ready    consumer accepts state_out
//     key_valid    a key has been loaded since reset
// ---------------------------------------------------------------------------
module round_key_add
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  state_t             cipher_key,
    input  state_t             state_in,
    input  logic               in_valid,
    output logic               in_ready,
    output state_t             state_out,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               key_valid
);

    state_t             key0;      // round-0 key, restored on wrap
    state_t             rk;        // key applied to the next accepted state
    logic [ROUND_W-1:0] round;     // round index of rk
    state_t             rk_next;
    word_t              sub_word;
    logic               accept;
    logic               last_round;

    // ------------------------------------------------------------------
    // Handshake. A key load owns the cycle, so nothing is accepted then.
    // The output register may take new data when empty or being drained.
    // ------------------------------------------------------------------
    assign in_ready   = key_valid & ~key_load & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign last_round = (round == ROUND_W'(NUM_ROUNDS));

    // ------------------------------------------------------------------
    // SubWord(RotWord(w[3])): RotWord lifts row r+1 of column 3 into byte
    // position r, so S-box r reads row (r+1)%4 and drives byte r of the
    // word (byte 0 is the MSB).
    // ------------------------------------------------------------------
    for (genvar r = 0; r < 4; r++) begin : g_sub
        aes_sbox u_sbox (
            .plain (rk[(r + 1) % 4][3]),
            .subst (sub_word[31 - 8*r -: 8])
        );
    end

    // ------------------------------------------------------------------
    // Next round key from rk: each new word chains off the previous new one.
    // ------------------------------------------------------------------
    always_comb begin
        word_t t;
        word_t n0, n1, n2, n3;
        // NOTE: every variable is given a value on entry, so no path through
        // this block can leave one unassigned and infer a latch.
        t       = sub_word ^ {rcon_lookup(round), 24'h0};
        n0      = col_word(rk, 2'd0) ^ t;
        n1      = col_word(rk, 2'd1) ^ n0;
        n2      = col_word(rk, 2'd2) ^ n1;
        n3      = col_word(rk, 2'd3) ^ n2;
        rk_next = words_to_state(n0, n1, n2, n3);
    end

    // ------------------------------------------------------------------
    // Key schedule state and output register.
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values; e.g. state_out uses the old rk even
    // though rk advances on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key0      <= '0;
            rk        <= '0;
            round     <= '0;
            key_valid <= 1'b0;
            state_out <= '0;
            out_round <= '0;
            out_valid <= 1'b0;
        end else if (key_load) begin
            key0      <= cipher_key;
            rk        <= cipher_key;
            round     <= '0;
            key_valid <= 1'b1;
            out_valid <= 1'b0;
        end else if (accept) begin
            state_out <= state_in ^ rk;
            out_round <= round;
            out_valid <= 1'b1;
            if (last_round) begin
                round <= '0;
                rk    <= key0;
            end else begin
                round <= round + 1'b1;
                rk    <= rk_next;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : round_key_add

// File: tb/tb_round_key_add.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_round_key_add
//   Self-checking bench for round_key_add. A behavioural model holds the
//   full expanded key table (computed with GF(2^8) arithmetic) and indexes it
//   by round; a compare process checks the DUT against the model every cycle.
//   Directed sections pin the model with FIPS-197 literals.
// ---------------------------------------------------------------------------
module tb_round_key_add;
    import aes_pkg::*;

    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               key_load;
    state_t             cipher_key;
    state_t             state_in;
    logic               in_valid;
    logic               in_ready;
    state_t             state_out;
    logic [ROUND_W-1:0] out_round;
    logic               out_valid;
    logic               out_ready;
    logic               key_valid;

    int n_checks = 0;
    int n_fail   = 0;

    round_key_add #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .state_in   (state_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_out  (state_out),
        .out_round  (out_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_valid  (key_valid)
    );

    always #10 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic state_t f2s(input logic [127:0] v);
        state_t     s;
        logic [1:0] r, c;
        for (int i = 0; i < 16; i++) begin
            r = 2'(i % 4);
            c = 2'(i / 4);
            s[r][c] = v[127 - 8*i -: 8];
        end
        return s;
    endfunction

    function automatic logic [127:0] s2f(input state_t s);
        logic [127:0] v;
        logic [1:0]   r, c;
        for (int i = 0; i < 16; i++) begin
            r = 2'(i % 4);
            c = 2'(i / 4);
            v[127 - 8*i -: 8] = s[r][c];
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]   m_sbox [256];
    logic [127:0] m_keys [0:10];
    logic         m_key_valid = 1'b0;
    logic         m_out_valid = 1'b0;
    logic [127:0] m_state_out = '0;
    int           m_out_round = 0;
    int           m_round     = 0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_sbox[x] = b;
        end
    endtask

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {m_sbox[w3[23:16]], m_sbox[w3[15:8]], m_sbox[w3[7:0]], m_sbox[w3[31:24]]}
             ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic expand_keys(input logic [127:0] k);
        logic [7:0] rc = 8'h01;
        m_keys[0] = k;
        for (int i = 1; i <= 10; i++) begin
            m_keys[i] = next_key(m_keys[i-1], rc);
            rc = xtime(rc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key_valid = 1'b0;
            m_out_valid = 1'b0;
            m_state_out = '0;
            m_out_round = 0;
            m_round     = 0;
        end else if (key_load) begin
            expand_keys(s2f(cipher_key));
            m_round     = 0;
            m_key_valid = 1'b1;
            m_out_valid = 1'b0;
        end else if (in_valid && m_key_valid && (!m_out_valid || out_ready)) begin
            m_state_out = s2f(state_in) ^ m_keys[m_round];
            m_out_round = m_round;
            m_out_valid = 1'b1;
            m_round     = (m_round == 10) ? 0 : m_round + 1;
        end else if (m_out_valid && out_ready) begin
            m_out_valid = 1'b0;
        end
    end

    // Compare process: inputs change at negedge+3, so negedge+2 is stable.
    always @(negedge clk) begin
        #2;
        check("key_valid", key_valid, m_key_valid);
        check("out_valid", out_valid, m_out_valid);
        check("in_ready", in_ready, m_key_valid && !key_load && (!m_out_valid || out_ready));
        if (m_out_valid) begin
            check("state_out", s2f(state_out), m_state_out);
            check("out_round", out_round, m_out_round);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic drive(input logic kl, input logic [127:0] key_f, input logic iv,
                         input logic [127:0] st_f, input logic ordy);
        key_load   = kl;
        cipher_key = f2s(key_f);
        in_valid   = iv;
        state_in   = f2s(st_f);
        out_ready  = ordy;
    endtask

    initial begin
        logic [127:0] held, st, k2;

        build_sbox();
        check("model_sbox_00", m_sbox[8'h00], 8'h63);
        check("model_sbox_53", m_sbox[8'h53], 8'hed);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) tick();
        check("rst_state_out", s2f(state_out), '0);
        check("rst_out_round", out_round, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        // 1: no key loaded -> never accepted
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1, rand128(), 1'b1);
            tick();
            check("nokey_in_ready", in_ready, 0);
            check("nokey_out_valid", out_valid, 0);
        end

        // 2: FIPS-197 round-0 AddRoundKey
        drive(1'b1, K, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, P, 1'b1);
        #1 check("t2_in_ready", in_ready, 1);
        tick();
        check("t2_state_out", s2f(state_out), C);
        check("t2_out_round", out_round, 0);
        check("t2_out_valid", out_valid, 1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();

        // 3: full schedule with zero states, then wrap
        drive(1'b1, K, 1'b0, '0, 1'b1);
        tick();
        check("model_rk1", m_keys[1], R1);
        check("model_rk10", m_keys[10], R10);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, '0, 1'b1, '0, 1'b1);
            tick();
            if (i == 1)       check("t3_rk1", s2f(state_out), R1);
            else if (i == 10) check("t3_rk10", s2f(state_out), R10);
            else if (i == 0 || i == 11) check("t3_rk0", s2f(state_out), K);
            else              check("t3_rk", s2f(state_out), m_keys[i]);
            check("t3_out_round", out_round, (i % 11));
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();

        // 4: stall for 5 cycles with in_valid held
        drive(1'b1, K, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, rand128(), 1'b1);
        tick();
        held = s2f(state_out);
        st   = rand128();
        drive(1'b0, '0, 1'b1, st, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stall_in_ready", in_ready, 0);
            check("t4_stall_hold", s2f(state_out), held);
            check("t4_stall_round", out_round, 0);
        end
        drive(1'b0, '0, 1'b1, st, 1'b1);
        #1 check("t4_release_in_ready", in_ready, 1);
        tick();
        check("t4_release_data", s2f(state_out), st ^ R1);
        check("t4_release_round", out_round, 1);
        drive(1'b0, '0, 1'b1, '0, 1'b1);
        tick();
        check("t4_next_round", out_round, 2);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();

        // 5: key_load at round 4 with in_valid=1
        drive(1'b1, rand128(), 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, rand128(), 1'b1);
            tick();
        end
        check("t5_pre_round", out_round, 3);
        k2 = rand128();
        drive(1'b1, k2, 1'b1, rand128(), 1'b1);
        #1 check("t5_load_in_ready", in_ready, 0);
        tick();
        check("t5_load_out_valid", out_valid, 0);
        check("t5_load_key_valid", key_valid, 1);
        st = rand128();
        drive(1'b0, '0, 1'b1, st, 1'b1);
        tick();
        check("t5_new_key_data", s2f(state_out), st ^ k2);
        check("t5_new_key_round", out_round, 0);

        // Randomised traffic with occasional key reloads
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) == 0), rand128(), ($urandom_range(0, 3) != 0),
                  rand128(), ($urandom_range(0, 3) != 0));
            tick();
        end

        // 6: asynchronous reset mid-stream
        drive(1'b0, '0, 1'b1, rand128(), 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_state_out", s2f(state_out), '0);
        check("t6_rst_out_round", out_round, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_key_valid", key_valid, 0);
        check("t6_rst_in_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, rand128(), 1'b1);
            tick();
            check("t6_nokey_in_ready", in_ready, 0);
        end
        drive(1'b1, K, 1'b0, '0, 1'b1);
        tick();
        check("t6_reload_key_valid", key_valid, 1);
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, '0, ($urandom_range(0, 1) != 0), rand128(), ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_round_key_add
